// File: rtl/mem_pkg.sv
// mem_pkg: default widths and the command record shared by the command-driven SRAM
package mem_pkg;
  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_FIFO_DEPTH = 4;
  localparam int MEM_RD_LAT = 2;
  typedef struct packed {
    logic write;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_cmd_t;
endpackage

// File: rtl/mem_cmd_fifo.sv
// mem_cmd_fifo: synchronous command FIFO with occupancy count, full/empty flags
module mem_cmd_fifo
  import mem_pkg::*;
#(
  parameter type T = mem_cmd_t,
  parameter int DEPTH = MEM_FIFO_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  T            din,
  input  logic        pop,
  output T            dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);
  T mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/mem_cmd_sram.sv
// mem_cmd_sram: FIFO-buffered write/read command SRAM with fixed-latency read return and monitor taps
module mem_cmd_sram
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int FIFO_DEPTH = MEM_FIFO_DEPTH,
  parameter int RD_LAT = MEM_RD_LAT,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_data,
  output logic              mon_write,
  output logic              mon_read,
  output logic [ADDR_W-1:0] mon_addr,
  output logic [DATA_W-1:0] mon_wdata,
  output logic [DATA_W-1:0] mon_rdata,
  output logic [CW-1:0]     fifo_cnt
);
  typedef struct packed {
    logic write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;
  cmd_t in_cmd, cmd;
  logic full, empty, pop, wr, rd;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [RD_LAT:0] pv;
  logic [ADDR_W-1:0] pa [RD_LAT+1];
  logic [DATA_W-1:0] pd [RD_LAT+1];
  logic mw;
  logic [ADDR_W-1:0] mwa;
  logic [DATA_W-1:0] mwd;
  assign in_cmd = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  assign cmd_ready = !full;
  assign pop = !empty;
  assign wr = pop && cmd.write;
  assign rd = pop && !cmd.write;
  mem_cmd_fifo #(.T(cmd_t), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(cmd_valid && !full),
    .din(in_cmd),
    .pop(pop),
    .dout(cmd),
    .full(full),
    .empty(empty),
    .count(fifo_cnt)
  );
  always_ff @(posedge clk)
    if (!reset && wr) mem[cmd.addr] <= cmd.wdata;
  always_ff @(posedge clk)
    if (reset) begin
      pv <= '0;
      for (int i = 0; i <= RD_LAT; i++) begin
        pa[i] <= '0;
        pd[i] <= '0;
      end
      mw <= 1'b0;
      mwa <= '0;
      mwd <= '0;
    end else begin
      pv <= {pv[RD_LAT-1:0], rd};
      pa[0] <= rd ? cmd.addr : '0;
      pd[0] <= rd ? mem[cmd.addr] : '0;
      for (int i = 1; i <= RD_LAT; i++) begin
        pa[i] <= pa[i-1];
        pd[i] <= pd[i-1];
      end
      mw <= wr;
      mwa <= wr ? cmd.addr : '0;
      mwd <= wr ? cmd.wdata : '0;
    end
  assign rsp_valid = pv[RD_LAT];
  assign rsp_addr = pa[RD_LAT];
  assign rsp_data = pd[RD_LAT];
  assign mon_write = mw;
  assign mon_read = pv[RD_LAT];
  assign mon_addr = mw ? mwa : pa[RD_LAT];
  assign mon_wdata = mwd;
  assign mon_rdata = pd[RD_LAT];
endmodule

// File: tb/tb_mem_cmd_sram.sv
// tb_mem_cmd_sram: randomized and directed checks of mem_cmd_sram against a queue-based reference model
module tb_mem_cmd_sram;
  localparam int DEPTH = 4;
  localparam int RD_LAT = 2;
  logic clk = 0;
  logic reset;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic rsp_valid, mon_write, mon_read;
  logic [7:0] rsp_addr, mon_addr;
  logic [31:0] rsp_data, mon_wdata, mon_rdata;
  logic [2:0] fifo_cnt;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  mem_cmd_sram #(.ADDR_W(8), .DATA_W(32), .FIFO_DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .mon_write(mon_write), .mon_read(mon_read), .mon_addr(mon_addr),
    .mon_wdata(mon_wdata), .mon_rdata(mon_rdata), .fifo_cnt(fifo_cnt)
  );
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", n, a, e, $time);
    end
  endtask
  typedef struct {bit w; logic [7:0] a; logic [31:0] d;} c_t;
  typedef struct {int due; logic [7:0] a; logic [31:0] d; bit k;} r_t;
  c_t q[$];
  r_t rq[$];
  logic [31:0] mem_m [256];
  bit known [256];
  bit armed = 0;
  int cyc = 0;
  bit e_rst, e_mw, e_rv, e_rk;
  logic [7:0] e_wa, e_ra;
  logic [31:0] e_wd, e_rd;
  int e_cnt;
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      q.delete();
      rq.delete();
      armed = 1;
      e_rst = 1;
      e_mw = 0;
      e_rv = 0;
    end else if (armed) begin
      bit pu;
      c_t c;
      r_t r;
      pu = cmd_valid && q.size() < DEPTH;
      e_rst = 0;
      e_mw = 0;
      e_rv = 0;
      if (q.size() > 0) begin
        c = q.pop_front();
        if (c.w) begin
          mem_m[c.a] = c.d;
          known[c.a] = 1;
          e_mw = 1;
          e_wa = c.a;
          e_wd = c.d;
        end else rq.push_back('{cyc + RD_LAT, c.a, mem_m[c.a], known[c.a]});
      end
      if (pu) q.push_back('{cmd_write, cmd_addr, cmd_wdata});
      if (rq.size() > 0 && rq[0].due == cyc) begin
        r = rq.pop_front();
        e_rv = 1;
        e_ra = r.a;
        e_rd = r.d;
        e_rk = r.k;
      end
    end
    e_cnt = q.size();
  end
  always @(negedge clk) if (armed) begin
    chk("cmd_ready", cmd_ready, e_cnt < DEPTH);
    chk("fifo_cnt", fifo_cnt, e_cnt);
    chk("rsp_valid", rsp_valid, e_rv);
    chk("mon_read", mon_read, e_rv);
    chk("mon_write", mon_write, e_mw);
    if (e_rst) begin
      chk("rst_rsp_addr", rsp_addr, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_mon_addr", mon_addr, 0);
      chk("rst_mon_wdata", mon_wdata, 0);
      chk("rst_mon_rdata", mon_rdata, 0);
    end
    if (e_mw) begin
      chk("mon_addr_w", mon_addr, e_wa);
      chk("mon_wdata", mon_wdata, e_wd);
    end
    if (e_rv) begin
      chk("rsp_addr", rsp_addr, e_ra);
      if (!e_mw) chk("mon_addr_r", mon_addr, e_ra);
      if (e_rk) begin
        chk("rsp_data", rsp_data, e_rd);
        chk("mon_rdata", mon_rdata, e_rd);
      end
    end
  end
  task automatic send(input bit w, input logic [7:0] a, input logic [31:0] d);
    bit rdy;
    cmd_valid = 1;
    cmd_write = w;
    cmd_addr = a;
    cmd_wdata = d;
    for (int t = 0; t < 200; t++) begin
      rdy = cmd_ready;
      @(negedge clk);
      if (rdy) return;
    end
    chk("send_timeout", 1, 0);
  endtask
  task automatic idle(input int n);
    cmd_valid = 0;
    repeat (n) @(negedge clk);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int seen;
    reset = 1;
    cmd_valid = 0;
    cmd_write = 0;
    cmd_addr = 0;
    cmd_wdata = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    chk("t1_cmd_ready", cmd_ready, 1);
    chk("t1_fifo_cnt", fifo_cnt, 0);
    chk("t1_rsp_valid", rsp_valid, 0);
    chk("t1_mon_write", mon_write, 0);
    chk("t1_mon_addr", mon_addr, 0);
    idle(2);
    send(1, 8'h10, 32'hDEAD_BEEF);
    send(0, 8'h10, 0);
    cmd_valid = 0;
    chk("t2_mon_write", mon_write, 1);
    chk("t2_mon_addr", mon_addr, 8'h10);
    chk("t2_mon_wdata", mon_wdata, 32'hDEAD_BEEF);
    repeat (RD_LAT) @(negedge clk);
    chk("t2_rsp_early", rsp_valid, 0);
    @(negedge clk);
    chk("t2_rsp_valid", rsp_valid, 1);
    chk("t2_rsp_data", rsp_data, 32'hDEAD_BEEF);
    idle(4);
    for (int a = 0; a < 256; a++) send(1, 8'(a), 32'(a * 3));
    for (int a = 0; a < 256; a++) send(0, 8'(a), 0);
    idle(8);
    send(1, 8'd5, 32'h1);
    send(0, 8'd5, 0);
    send(1, 8'd5, 32'h2);
    send(0, 8'd5, 0);
    cmd_valid = 0;
    repeat (RD_LAT - 1) @(negedge clk);
    chk("t5_first_valid", rsp_valid, 1);
    chk("t5_first_data", rsp_data, 32'h1);
    repeat (2) @(negedge clk);
    chk("t5_second_valid", rsp_valid, 1);
    chk("t5_second_data", rsp_data, 32'h2);
    idle(4);
    for (int i = 0; i < 6; i++) send(i[0], 8'(40 + i), 32'(100 + i));
    idle(8);
    for (int i = 0; i < 3000; i++) begin
      if (!(cmd_valid && !cmd_ready)) begin
        cmd_valid = ($urandom % 4) != 0;
        cmd_write = 1'($urandom % 2);
        cmd_addr = cmd_write ? 8'($urandom % 32) : 8'($urandom);
        cmd_wdata = $urandom;
      end
      reset = ($urandom % 400) == 0;
      @(negedge clk);
    end
    reset = 0;
    idle(8);
    for (int i = 0; i < 4; i++) send(0, 8'(200 + i), 0);
    cmd_valid = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("t6_rsp_after_reset", seen, 0);
    chk("t6_fifo_empty", fifo_cnt, 0);
    send(0, 8'd200, 0);
    cmd_valid = 0;
    repeat (RD_LAT) @(negedge clk);
    @(negedge clk);
    chk("t6_valid", rsp_valid, 1);
    chk("t6_retained", rsp_data, 32'h258);
    idle(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
